aexm_wbsched: RTL

- Write-back scheduler and load scoreboard for the AEXM register file.
- Shares the single register-file write port between two sources:
  - the in-order ALU result path, which cannot stall;
  - out-of-order load returns from the data cache, which arrive late on a miss.
- Tracks destination registers of outstanding loads and stalls decode on RAW/WAW hazards against them.
- Sits between decode/execute, the dcache return channel and the register file write port (WE/WADDR/WDATA).

---
 rtl/aexm_pkg.sv | 10 +
 rtl/aexm_wbfifo.sv | 47 ++++
 rtl/aexm_wbsched.sv | 93 +++++++++
 3 files changed

// File: rtl/aexm_pkg.sv
// aexm_pkg: shared widths, r0 constant and the load-return entry for the AEXM write-back path.
package aexm_pkg;
    localparam int AEXM_REG_W  = 5;
    localparam int AEXM_DATA_W = 32;
    localparam logic [AEXM_REG_W-1:0] AEXM_R0 = '0;
    typedef struct packed {
        logic [AEXM_REG_W-1:0]  rd;
        logic [AEXM_DATA_W-1:0] data;
    } ld_entry_t;
endpackage

// File: rtl/aexm_wbfifo.sv
// aexm_wbfifo: power-of-two synchronous FIFO with a registered full flag and an occupancy counter.
module aexm_wbfifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 37
) (
    input  logic                     gclk,
    input  logic                     grst,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_din,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          r_full;
    logic          w_push, w_pop;
    logic [AW:0]   w_cnt_nxt;
    assign w_push    = i_push & ~r_full;
    assign w_pop     = i_pop & (r_cnt != '0);
    assign w_cnt_nxt = r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    assign o_dout    = r_mem[r_rp];
    assign o_full    = r_full;
    assign o_empty   = (r_cnt == '0);
    assign o_cnt     = r_cnt;
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == (AW+1)'(DEPTH));
        end
    end
    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge gclk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end
endmodule

// File: rtl/aexm_wbsched.sv
// aexm_wbsched: arbitrates the register-file write port between the ALU and buffered load returns,
// and keeps a load scoreboard that stalls decode on hazards against outstanding loads.
module aexm_wbsched
    import aexm_pkg::*;
#(
    parameter int LD_MAX   = 4,
    parameter int LQ_DEPTH = 2
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        iss_vld,
    input  logic        iss_ld,
    input  logic [4:0]  iss_ra,
    input  logic [4:0]  iss_rb,
    input  logic [4:0]  iss_rs,
    input  logic        iss_st,
    input  logic [4:0]  iss_rd,
    output logic        d_stall,
    input  logic        alu_we,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_vld,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_rdy,
    output logic        wp_we,
    output logic [4:0]  wp_addr,
    output logic [31:0] wp_data,
    output logic [3:0]  pend_cnt
);
    localparam int CW = $clog2(LQ_DEPTH) + 1;
    logic [31:0]   r_sb, w_sb_nxt;
    logic [3:0]    r_pend;
    logic          r_wp_we;
    logic [4:0]    r_wp_addr;
    logic [31:0]   r_wp_data;
    ld_entry_t     w_head, w_din;
    logic          w_empty, w_full, w_alu, w_pop, w_pop_wr, w_ld_iss, w_unused;
    logic [CW-1:0] w_cnt;
    assign w_din  = '{rd: ld_rd, data: ld_data};
    aexm_wbfifo #(.DEPTH(LQ_DEPTH), .DW($bits(ld_entry_t))) u_fifo (
        .gclk    (gclk),
        .grst    (grst),
        .i_push  (ld_vld),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (w_cnt)
    );
    assign w_unused = ^w_cnt;
    assign ld_rdy   = ~w_full;
    assign w_alu    = alu_we & (alu_rd != AEXM_R0);
    assign w_pop    = ~w_alu & ~w_empty;
    // A stray return to r0 still drains, but never writes or releases a count.
    assign w_pop_wr = w_pop & (w_head.rd != AEXM_R0);
    assign d_stall  = iss_vld & (r_sb[iss_ra] | r_sb[iss_rb] | (iss_st & r_sb[iss_rs]) |
                      ((iss_rd != AEXM_R0) & r_sb[iss_rd]) | (iss_ld & (r_pend == 4'(LD_MAX))));
    assign w_ld_iss = iss_vld & ~d_stall & iss_ld & (iss_rd != AEXM_R0);
    always_comb begin
        w_sb_nxt = r_sb;
        if (w_pop_wr) w_sb_nxt[w_head.rd] = 1'b0;
        if (w_ld_iss) w_sb_nxt[iss_rd] = 1'b1;
    end
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            r_sb      <= '0;
            r_pend    <= '0;
            r_wp_we   <= 1'b0;
            r_wp_addr <= '0;
            r_wp_data <= '0;
        end else begin
            r_sb   <= w_sb_nxt;
            r_pend <= r_pend + {3'b0, w_ld_iss} - {3'b0, w_pop_wr};
            if (w_alu) begin
                r_wp_we   <= 1'b1;
                r_wp_addr <= alu_rd;
                r_wp_data <= alu_data;
            end else if (w_pop_wr) begin
                r_wp_we   <= 1'b1;
                r_wp_addr <= w_head.rd;
                r_wp_data <= w_head.data;
            end else begin
                r_wp_we   <= 1'b0;
            end
        end
    end
    assign wp_we    = r_wp_we;
    assign wp_addr  = r_wp_addr;
    assign wp_data  = r_wp_data;
    assign pend_cnt = r_pend;
endmodule
